// File: rtl/uart_echo.sv
// rtl/uart_echo.sv - 8N1 UART loopback: RX deserializer, byte FIFO, TX serializer
module uart_echo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 280,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic tx_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] HALF_M1   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_M1    = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // RX path state
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_sync_q, rx_sync_d;
  rx_state_t             rx_state_q, rx_state_d;
  logic [TW-1:0]         rx_timer_q, rx_timer_d;
  logic [IW-1:0]         rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_push_q, rx_push_d;

  // FIFO state
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  fifo_pop;
  logic                  fifo_push_ok;
  logic                  fifo_empty;
  logic                  fifo_full;

  // TX path state
  tx_state_t             tx_state_q, tx_state_d;
  logic [TW-1:0]         tx_timer_q, tx_timer_d;
  logic [IW-1:0]         tx_idx_q, tx_idx_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_q, tx_d;

  assign tx_o = tx_q;

  // Two-flop synchronizer on the asynchronous serial input
  always_comb begin
    rx_meta_d = rx_i;
    rx_sync_d = rx_meta_q;
  end

  // RX deserializer: start detect, mid-bit sampling, stop check and push strobe
  always_comb begin
    rx_state_d = rx_state_q;
    rx_timer_d = rx_timer_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_push_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_timer_d = '0;
          rx_idx_d   = '0;
        end
      end
      RX_START: begin
        if (rx_timer_q == HALF_M1) begin
          rx_timer_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_timer_d = rx_timer_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_timer_q == BIT_M1) begin
          rx_timer_d = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
          rx_idx_d   = rx_idx_q + 1'b1;
          if (rx_idx_q == LAST_IDX) rx_state_d = RX_STOP;
        end else begin
          rx_timer_d = rx_timer_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_timer_q == BIT_M1) begin
          rx_timer_d = '0;
          if (rx_sync_q) begin
            rx_push_d  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_ERR;
          end
        end else begin
          rx_timer_d = rx_timer_q + 1'b1;
        end
      end
      RX_ERR: begin
        // Framing error: hold off until the line returns high before rearming
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Byte FIFO: a push into a full FIFO is dropped unless a pop frees a slot
  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == FIFO_FULL);
    fifo_push_ok = rx_push_q && (!fifo_full || fifo_pop);
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (fifo_push_ok) begin
      mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({fifo_push_ok, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // TX serializer: pops when idle, line value registered from current state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_timer_d = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tx_timer_q == BIT_M1) begin
          tx_timer_d = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_timer_d = tx_timer_q + 1'b1;
        end
      end
      TX_DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_timer_q == BIT_M1) begin
          tx_timer_d = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = tx_idx_q + 1'b1;
          if (tx_idx_q == LAST_IDX) tx_state_d = TX_STOP;
        end else begin
          tx_timer_d = tx_timer_q + 1'b1;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (tx_timer_q == BIT_M1) begin
          tx_timer_d = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_timer_d = tx_timer_q + 1'b1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any frame and leaves the line idle-high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_timer_q <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_push_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_state_q <= TX_IDLE;
      tx_timer_q <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_push_q  <= rx_push_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_echo.sv
// tb/tb_uart_echo.sv - directed testbench for uart_echo
module tb_uart_echo;

  localparam int CPB     = 280;
  localparam int LATENCY = 2666;  // rx start drive -> tx falling edge, in cycles
  localparam int RX_WAIT = 4000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic rx_i  = 1'b1;
  logic tx_o;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  uart_echo #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    start_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      rx_i = f[i];
      if (i == 0) start_cyc = cyc;
      repeat (CPB - 1) @(negedge clk_i);
    end
    if (!stop_bit) begin
      @(negedge clk_i);
      rx_i = 1'b1;
    end
  endtask

  task automatic recv_frame(output logic got, output logic [7:0] b, output logic ok,
                            output int fall_cyc);
    logic start_ok;
    got = 1'b0;
    b = '0;
    ok = 1'b0;
    fall_cyc = 0;
    for (int i = 0; i < RX_WAIT && !got; i++) begin
      @(negedge clk_i);
      if (tx_o === 1'b0) got = 1'b1;
    end
    if (got) begin
      fall_cyc = cyc;
      repeat (CPB / 2) @(negedge clk_i);
      start_ok = (tx_o === 1'b0);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk_i);
        b[k] = tx_o;
      end
      repeat (CPB) @(negedge clk_i);
      ok = start_ok && (tx_o === 1'b1);
    end
  endtask

  task automatic watch_idle(input int ncyc, output logic quiet);
    quiet = 1'b1;
    repeat (ncyc) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) quiet = 1'b0;
    end
  endtask

  task automatic echo_one(input logic [7:0] b, input string name);
    logic got, ok;
    logic [7:0] rb;
    int c0, fc;
    fork
      send_frame(b, 1'b1, c0);
      recv_frame(got, rb, ok, fc);
    join
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: no tx start within %0d cycles, required a frame", name, RX_WAIT);
    end
    n_checks++;
    if (rb !== b) begin
      n_fail++;
      $display("FAIL %s_data: got 0x%02h, required 0x%02h", name, rb, b);
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_framing: start/stop ok=%0b, required 1", name, ok);
    end
  endtask

  task automatic test_reset;
    logic quiet;
    rx_i = 1'b1;
    rst_i = 1'b1;
    repeat (5) @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_during: tx_o=%b, required 1", tx_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_after: tx_o=%b, required 1", tx_o);
    end
    watch_idle(10000, quiet);
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_quiet: tx activity=%0b, required 0", !quiet);
    end
  endtask

  task automatic test_single;
    logic got, ok;
    logic [7:0] rb;
    int c0, fc;
    fork
      send_frame(8'hA5, 1'b1, c0);
      recv_frame(got, rb, ok, fc);
    join
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL a5_timeout: no tx start within %0d cycles, required a frame", RX_WAIT);
    end
    n_checks++;
    if (rb !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_data: got 0x%02h, required 0xa5", rb);
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_framing: start/stop ok=%0b, required 1", ok);
    end
    n_checks++;
    if (fc - c0 !== LATENCY) begin
      n_fail++;
      $display("FAIL a5_latency: tx fell %0d cycles after rx start, required %0d", fc - c0, LATENCY);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3];
    logic [7:0] rb [3];
    logic got [3];
    logic ok [3];
    int c0, fc;
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h55;
    fork
      begin
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, c0);
      end
      begin
        for (int j = 0; j < 3; j++) recv_frame(got[j], rb[j], ok[j], fc);
      end
    join
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 1'b1 || rb[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL b2b_data%0d: got 0x%02h (seen=%0b), required 0x%02h", i, rb[i], got[i], exp_b[i]);
      end
      n_checks++;
      if (ok[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_framing%0d: start/stop ok=%0b, required 1", i, ok[i]);
      end
    end
  endtask

  task automatic test_framing_error;
    logic quiet;
    int c0;
    send_frame(8'h3C, 1'b0, c0);
    watch_idle(3500, quiet);
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_quiet: tx activity=%0b, required 0", !quiet);
    end
    echo_one(8'h12, "ferr_next");
  endtask

  task automatic test_glitch;
    logic quiet;
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (100) @(negedge clk_i);
    rx_i = 1'b1;
    watch_idle(3000, quiet);
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_quiet: tx activity=%0b, required 0", !quiet);
    end
  endtask

  task automatic test_reset_mid_echo;
    logic quiet;
    int c0;
    send_frame(8'hC3, 1'b1, c0);
    // land inside data bit 2 of the echo, which is 0 for 0xC3
    repeat (816) @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_inflight: tx_o=%b, required 0", tx_o);
    end
    #3;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_async: tx_o=%b, required 1", tx_o);
    end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    watch_idle(3000, quiet);
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_residual: tx activity=%0b, required 0", !quiet);
    end
    echo_one(8'h7E, "rst_mid_next");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing_error();
    test_glitch();
    test_reset_mid_echo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
